// File: rtl/bpd_update_queue.sv
// Commit-to-BPD update queue: collects up to two resolved branches per cycle and issues one per cycle.
// Optional statistics counters are enabled by defining BPD_UPD_STATS_EN.
module bpd_update_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cm0_valid,
    input  logic [PC_W-1:0] cm0_pc,
    input  logic            cm0_taken,
    input  logic [PC_W-1:0] cm0_target,
    input  logic            cm0_mispred,
    input  logic            cm1_valid,
    input  logic [PC_W-1:0] cm1_pc,
    input  logic            cm1_taken,
    input  logic [PC_W-1:0] cm1_target,
    input  logic            cm1_mispred,
    output logic            cm_stall,
    output logic            upd_valid,
    input  logic            upd_ready,
    output logic [PC_W-1:0] upd_pc,
    output logic [PC_W-1:0] upd_target,
    output logic            upd_taken,
    output logic            upd_mispred,
`ifdef BPD_UPD_STATS_EN
    output logic [31:0]     stat_br,
    output logic [31:0]     stat_mis,
`endif
    output logic [7:0]      drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] target;
        logic            mispred;
    } upd_entry_t;

    upd_entry_t        mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic              pop, acc0, acc1;
    logic [CW-1:0]     free_slots;
    logic [1:0]        drops;
    logic [8:0]        drop_sum;
    logic [PW-1:0]     wr1_ptr;
    upd_entry_t        head;

    // Head is read straight from registered storage, so no input reaches upd_* combinationally.
    assign head        = mem[rd_ptr];
    assign upd_valid   = (count != '0);
    assign upd_pc      = head.pc;
    assign upd_target  = head.target;
    assign upd_taken   = head.taken;
    assign upd_mispred = head.mispred;
    assign cm_stall    = (count > CW'(DEPTH - 2));

    // A pop in the same cycle frees its slot before pushes are admitted.
    assign pop        = upd_valid && upd_ready;
    assign free_slots = CW'(DEPTH) - count + CW'(pop);
    assign acc0       = cm0_valid && (free_slots >= CW'(1));
    assign acc1       = cm1_valid && (free_slots >= (CW'(1) + CW'(acc0)));
    assign drops      = 2'(cm0_valid && !acc0) + 2'(cm1_valid && !acc1);
    assign drop_sum   = {1'b0, drop_cnt} + 9'(drops);
    assign wr1_ptr    = wr_ptr + PW'(acc0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (acc0) mem[wr_ptr]  <= '{cm0_pc, cm0_taken, cm0_target, cm0_mispred};
            if (acc1) mem[wr1_ptr] <= '{cm1_pc, cm1_taken, cm1_target, cm1_mispred};
            wr_ptr   <= wr_ptr + PW'(acc0) + PW'(acc1);
            rd_ptr   <= rd_ptr + PW'(pop);
            count    <= count + CW'(acc0) + CW'(acc1) - CW'(pop);
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

`ifdef BPD_UPD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br  <= '0;
            stat_mis <= '0;
        end else begin
            stat_br  <= stat_br + 32'(acc0) + 32'(acc1);
            stat_mis <= stat_mis + 32'(acc0 && cm0_mispred) + 32'(acc1 && cm1_mispred);
        end
    end
`endif
endmodule
